// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle multiplier.
// Each grant runs one multiply, which ends on completion, abort or timeout, then one clear cycle.
module mul_arbiter #(
  parameter int          WIDTH   = 64,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     op_a0,
  input  logic [WIDTH-1:0]     op_b0,
  input  logic [WIDTH-1:0]     op_a1,
  input  logic [WIDTH-1:0]     op_b1,
  output logic [1:0]           gnt,
  output logic [1:0]           rsp_valid,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 err,
  output logic                 busy,
  output logic                 mul_start,
  output logic                 mul_clear,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_result
);

  // IDLE: arbitrate | BUSY: multiplier running | CLR: one-cycle clear before next grant
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    CLR  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 win;
  logic                 granted_req;

  // With both requesting, rr picks; a lone request wins regardless of rr.
  assign win         = (req == 2'b11) ? rr_q : req[1];
  assign granted_req = gnt_q[1] ? req[1] : req[0];

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rsp_valid_d = 2'b00;
    err_d       = 1'b0;
    rsp_data_d  = rsp_data_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = BUSY;
          gnt_d   = win ? 2'b10 : 2'b01;
          rr_d    = ~win;
          cnt_d   = 16'd0;
          mul_a_d = win ? op_a1 : op_a0;
          mul_b_d = win ? op_b1 : op_b0;
        end
      end
      BUSY: begin
        if (!granted_req) begin
          state_d = CLR;
        end else if (mul_done) begin
          state_d     = CLR;
          rsp_data_d  = mul_result;
          rsp_valid_d = gnt_q;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          state_d = CLR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CLR: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= 16'd0;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = (state_q != IDLE);
  assign mul_start = (state_q == BUSY);
  assign mul_clear = (state_q != BUSY);

endmodule

// File: tb/tb_mul_arbiter.sv
// Transaction-level bench for mul_arbiter: the bench plays the multiplier and
// predicts grant order, results, aborts and timeouts from the arbitration rules.
module tb_mul_arbiter;
  localparam int          W  = 64;
  localparam logic [15:0] TO = 16'd4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req;
  logic [W-1:0]     op_a0, op_b0, op_a1, op_b1;
  logic [1:0]       gnt, rsp_valid;
  logic [2*W-1:0]   rsp_data;
  logic             err, busy, mul_start, mul_clear;
  logic [W-1:0]     mul_a, mul_b;
  logic             mul_done;
  logic [2*W-1:0]   mul_result;

  int checks   = 0;
  int failures = 0;

  // Reference state: who has priority next, and the last delivered product.
  logic             m_rr;
  logic [2*W-1:0]   m_data;

  mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .busy(busy), .mul_start(mul_start), .mul_clear(mul_clear),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // mode: 0 = completes after d BUSY cycles, 1 = abort with mul_done=1,
  //       2 = timeout, 3 = abort with random mul_done
  task automatic txn(input logic [1:0] pat, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input int mode, input int d);
    logic           win;
    logic [1:0]     oh;
    logic [W-1:0]   ea, eb;
    logic [2*W-1:0] prod;
    int             nb;
    win  = (pat == 2'b11) ? m_rr : pat[1];
    oh   = win ? 2'b10 : 2'b01;
    ea   = win ? a1 : a0;
    eb   = win ? b1 : b0;
    prod = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
    req = pat; op_a0 = a0; op_b0 = b0; op_a1 = a1; op_b1 = b1; mul_done = 1'b0;
    @(negedge clk);
    m_rr = ~win;
    chk_eq("grant", gnt, oh);
    chk_eq("start", mul_start, 1);
    chk_eq("clear_busy", mul_clear, 0);
    chk_eq("mul_a", mul_a, ea);
    chk_eq("mul_b", mul_b, eb);
    nb = 1;
    if (mode == 2) begin
      repeat (int'(TO) - 1) begin
        @(negedge clk);
        if (mul_start) nb++;
        chk_eq("to_wait_err", err, 0);
      end
      @(negedge clk);
      chk_eq("to_err", err, 1);
      chk_eq("to_busy_cycles", nb, TO);
      chk_eq("to_rsp_valid", rsp_valid, 0);
      chk_eq("to_rsp_data", rsp_data, m_data);
      chk_eq("to_clear", mul_clear, 1);
    end else begin
      repeat (d - 1) begin
        @(negedge clk);
        chk_eq("wait_start", mul_start, 1);
        chk_eq("wait_rsp_valid", rsp_valid, 0);
        chk_eq("hold_rsp_data", rsp_data, m_data);
        chk_eq("hold_mul_a", mul_a, ea);
      end
      if (mode == 1 || mode == 3) begin
        req[win]   = 1'b0;
        mul_done   = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        mul_result = {rnd64(), rnd64()};
      end else begin
        mul_done   = 1'b1;
        mul_result = prod;
        m_data     = prod;
      end
      @(negedge clk);
      chk_eq("rsp_valid", rsp_valid, (mode == 0) ? oh : 2'b00);
      chk_eq("rsp_data", rsp_data, m_data);
      chk_eq("no_err", err, 0);
      chk_eq("clr_clear", mul_clear, 1);
      chk_eq("clr_start", mul_start, 0);
      chk_eq("clr_gnt", gnt, oh);
      chk_eq("clr_busy", busy, 1);
    end
    mul_done = 1'b0;
    req      = pat & ~oh;
    @(negedge clk);
    chk_eq("idle_gnt", gnt, 0);
    chk_eq("idle_busy", busy, 0);
    chk_eq("idle_pulses", {err, rsp_valid}, 0);
  endtask

  initial begin
    reset_n = 1'b0; req = 2'b11; mul_done = 1'b0; mul_result = '0;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
    m_rr = 1'b0; m_data = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_gnt", gnt, 0);
    chk_eq("rst_start", mul_start, 0);
    chk_eq("rst_clear", mul_clear, 1);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_data", rsp_data, 0);
    chk_eq("rst_pulses", {err, rsp_valid}, 0);
    reset_n = 1'b1;

    // Contention held from reset: expect 01, 10, 01.
    for (int i = 0; i < 3; i++)
      txn(2'b11, rnd64(), rnd64(), rnd64(), rnd64(), 0, i + 1);
    // Lone request wins even though rr now favours requester 1.
    txn(2'b01, 64'd5, 64'd24, 64'd0, 64'd0, 0, 3);
    chk_eq("single_product", rsp_data, 128'd120);
    txn(2'b10, rnd64(), rnd64(), rnd64(), rnd64(), 1, 2);
    txn(2'b01, rnd64(), rnd64(), rnd64(), rnd64(), 2, 0);
    txn(2'b01, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd0, 0, 2);
    chk_eq("wide_product", rsp_data, 128'h0000_0000_0000_0001_0000_0000_0000_0000);

    for (int i = 0; i < 40; i++) begin
      int sel, mode;
      sel  = $urandom_range(0, 9);
      mode = (sel < 6) ? 0 : (sel < 8) ? 3 : (sel < 9) ? 1 : 2;
      txn(2'($urandom_range(1, 3)), rnd64(), rnd64(), rnd64(), rnd64(), mode,
          $urandom_range(1, int'(TO)));
    end

    // Reset in the middle of BUSY.
    req = 2'b01; op_a0 = rnd64(); op_b0 = rnd64();
    @(negedge clk);
    @(negedge clk);
    chk_eq("pre_rst_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk_eq("midrst_gnt", gnt, 0);
    chk_eq("midrst_start", mul_start, 0);
    chk_eq("midrst_clear", mul_clear, 1);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_data", rsp_data, 0);
    chk_eq("midrst_mul_a", mul_a, 0);
    chk_eq("midrst_pulses", {err, rsp_valid}, 0);
    m_rr = 1'b0; m_data = '0; req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    txn(2'b10, rnd64(), rnd64(), rnd64(), rnd64(), 0, 2);
    txn(2'b11, rnd64(), rnd64(), rnd64(), rnd64(), 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
